// File: rtl/exe_mem_issue_if.sv
// SRAM-like data bus between the EXE issue unit (master) and the bus bridge (slave).
interface exe_mem_issue_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok
  );
endinterface

// File: rtl/exe_mem_issue.sv
// EXE-stage load/store issue: address translation, memory exception check,
// registered SRAM-bus request and outstanding/cancelled response tracking.
module exe_mem_issue #(
  parameter int NUM_DMW   = 2,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_store,
  input  logic [1:0]           in_size,
  input  logic [31:0]          in_vaddr,
  input  logic [31:0]          in_wdata,
  input  logic                 flush,
  input  logic                 crmd_da,
  input  logic                 crmd_pg,
  input  logic [1:0]           cur_plv,
  input  logic [NUM_DMW*8-1:0] dmw_cfg,
  output logic [18:0]          tlb_vppn,
  output logic                 tlb_va_bit12,
  input  logic                 tlb_found,
  input  logic                 tlb_v,
  input  logic                 tlb_d,
  input  logic [19:0]          tlb_ppn,
  input  logic [5:0]           tlb_ps,
  input  logic [1:0]           tlb_plv,
  exe_mem_issue_if.master      bus,
  output logic                 resp_valid,
  output logic                 resp_discard,
  output logic                 excp_valid,
  output logic [5:0]           excp_code,
  output logic [31:0]          excp_badv,
  output logic [CNT_W-1:0]     outst_cnt
);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  logic        req_q, wr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q, wdata_q;
  logic [CNT_W-1:0] cancel_cnt;

  assign bus.data_sram_req   = req_q;
  assign bus.data_sram_wr    = wr_q;
  assign bus.data_sram_size  = size_q;
  assign bus.data_sram_wstrb = wstrb_q;
  assign bus.data_sram_addr  = addr_q;
  assign bus.data_sram_wdata = wdata_q;

  logic data_ok, addr_ok;
  assign data_ok = bus.data_sram_data_ok;
  assign addr_ok = bus.data_sram_addr_ok;

  assign tlb_vppn     = in_vaddr[31:13];
  assign tlb_va_bit12 = in_vaddr[12];

  // A response arriving this cycle can free a slot for a same-cycle accept.
  assign in_ready = (state == IDLE) & ~flush &
                    ((outst_cnt < CNT_W'(MAX_OUTST)) | data_ok);
  logic accept;
  assign accept = in_valid & in_ready;

  // ---- translation
  logic direct;
  assign direct = crmd_da & ~crmd_pg;

  logic [NUM_DMW-1:0] dmw_hit;
  for (genvar i = 0; i < NUM_DMW; i++) begin : g_dmw
    assign dmw_hit[i] = (dmw_cfg[8*i+5 +: 3] == in_vaddr[31:29]) &
                        ((dmw_cfg[8*i+1] & (cur_plv == 2'd3)) |
                         (dmw_cfg[8*i]   & (cur_plv == 2'd0)));
  end

  logic [2:0] dmw_pseg;
  always_comb begin
    dmw_pseg = '0;
    // walk downward so the lowest hitting window wins
    for (int i = NUM_DMW - 1; i >= 0; i--)
      if (dmw_hit[i]) dmw_pseg = dmw_cfg[8*i+2 +: 3];
  end

  logic use_tlb;
  assign use_tlb = ~direct & ~(|dmw_hit);

  logic [31:0] pa;
  always_comb begin
    if (direct)               pa = in_vaddr;
    else if (|dmw_hit)        pa = {dmw_pseg, in_vaddr[28:0]};
    else if (tlb_ps == 6'd21) pa = {tlb_ppn[19:9], in_vaddr[20:0]};
    else                      pa = {tlb_ppn, in_vaddr[11:0]};
  end

  // ---- exceptions, one-hot {ALE,TLBR,PIL,PIS,PPI,PME}
  logic ale;
  assign ale = ((in_size == 2'd1) & in_vaddr[0]) |
               ((in_size == 2'd2) & (|in_vaddr[1:0])) |
               (in_size == 2'd3);

  logic [5:0] code_n;
  always_comb begin
    code_n = 6'b000000;
    if (ale)                                  code_n = 6'b100000;
    else if (use_tlb & ~tlb_found)            code_n = 6'b010000;
    else if (use_tlb & ~tlb_v & ~in_is_store) code_n = 6'b001000;
    else if (use_tlb & ~tlb_v &  in_is_store) code_n = 6'b000100;
    else if (use_tlb & (cur_plv > tlb_plv))   code_n = 6'b000010;
    else if (use_tlb & in_is_store & ~tlb_d)  code_n = 6'b000001;
  end

  // ---- store byte lanes
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  always_comb begin
    wstrb_n = 4'b0000;
    wdata_n = in_wdata;
    case (in_size)
      2'd0: begin
        wstrb_n = 4'b0001 << in_vaddr[1:0];
        wdata_n = {4{in_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_n = 4'b0011 << in_vaddr[1:0];
        wdata_n = {2{in_wdata[15:0]}};
      end
      default: wstrb_n = 4'b1111;
    endcase
    if (!in_is_store) wstrb_n = 4'b0000;
  end

  // ---- responses
  assign resp_discard = data_ok & (cancel_cnt != '0);
  assign resp_valid   = data_ok & (cancel_cnt == '0);

  logic inc;
  assign inc = (state == REQ) & addr_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      wstrb_q    <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      excp_valid <= 1'b0;
      excp_code  <= 6'd0;
      excp_badv  <= 32'd0;
      outst_cnt  <= '0;
      cancel_cnt <= '0;
    end else begin
      excp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (|code_n) begin
            excp_valid <= 1'b1;
            excp_code  <= code_n;
            excp_badv  <= in_vaddr;
          end else begin
            state   <= REQ;
            req_q   <= 1'b1;
            wr_q    <= in_is_store;
            size_q  <= in_size;
            wstrb_q <= wstrb_n;
            addr_q  <= pa;
            wdata_q <= wdata_n;
          end
        end
        REQ: if (addr_ok) begin
          state <= IDLE;
          req_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      outst_cnt <= outst_cnt + CNT_W'(inc) - CNT_W'(data_ok);

      // an in-flight request cannot be withdrawn, so it is cancelled too
      if (flush) begin
        excp_valid <= 1'b0;
        cancel_cnt <= outst_cnt - CNT_W'(data_ok) + CNT_W'(state == REQ);
      end else if (resp_discard) begin
        cancel_cnt <= cancel_cnt - CNT_W'(1);
      end
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
    !(data_ok && outst_cnt == '0));

endmodule

// File: tb/tb_exe_mem_issue.sv
// Directed bench for exe_mem_issue: translation modes, exceptions, bus hold,
// outstanding limit and flush-cancelled responses.
module tb_exe_mem_issue;
  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, in_is_store;
  logic [1:0]  in_size;
  logic [31:0] in_vaddr, in_wdata;
  logic        flush, crmd_da, crmd_pg;
  logic [1:0]  cur_plv;
  logic [15:0] dmw_cfg;
  logic [18:0] tlb_vppn;
  logic        tlb_va_bit12, tlb_found, tlb_v, tlb_d;
  logic [19:0] tlb_ppn;
  logic [5:0]  tlb_ps;
  logic [1:0]  tlb_plv;
  logic        resp_valid, resp_discard, excp_valid;
  logic [5:0]  excp_code;
  logic [31:0] excp_badv;
  logic [2:0]  outst_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  exe_mem_issue_if bus();

  exe_mem_issue #(.NUM_DMW(2), .MAX_OUTST(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_size(in_size), .in_vaddr(in_vaddr), .in_wdata(in_wdata),
    .flush(flush), .crmd_da(crmd_da), .crmd_pg(crmd_pg), .cur_plv(cur_plv),
    .dmw_cfg(dmw_cfg), .tlb_vppn(tlb_vppn), .tlb_va_bit12(tlb_va_bit12),
    .tlb_found(tlb_found), .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_ppn(tlb_ppn),
    .tlb_ps(tlb_ps), .tlb_plv(tlb_plv), .bus(bus.master),
    .resp_valid(resp_valid), .resp_discard(resp_discard),
    .excp_valid(excp_valid), .excp_code(excp_code), .excp_badv(excp_badv),
    .outst_cnt(outst_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [1:0] sz,
                       input logic [31:0] va, input logic [31:0] wd);
    in_valid = 1'b1; in_is_store = st; in_size = sz; in_vaddr = va; in_wdata = wd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic complete();
    bus.data_sram_addr_ok = 1'b1; step(); bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1; step(); bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic excp_case(input string tag, input logic st, input logic [31:0] va,
                           input logic [5:0] code);
    issue(st, st ? 2'd1 : 2'd2, va, 32'h0);
    chk({tag, "_valid"}, excp_valid, 1'b1);
    chk({tag, "_code"}, excp_code, code);
    chk({tag, "_badv"}, excp_badv, va);
    chk({tag, "_noreq"}, bus.data_sram_req, 1'b0);
    step();
    chk({tag, "_pulse"}, excp_valid, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; in_valid = 0; in_is_store = 0; in_size = 0; in_vaddr = 0;
    in_wdata = 0; flush = 0; crmd_da = 1; crmd_pg = 0; cur_plv = 0; dmw_cfg = 0;
    tlb_found = 0; tlb_v = 0; tlb_d = 0; tlb_ppn = 0; tlb_ps = 0; tlb_plv = 0;
    bus.data_sram_addr_ok = 0; bus.data_sram_data_ok = 0;
    step(); step();
    chk("rst_req", bus.data_sram_req, 1'b0);
    chk("rst_addr", bus.data_sram_addr, 32'h0);
    chk("rst_wstrb", bus.data_sram_wstrb, 4'h0);
    chk("rst_excp", excp_valid, 1'b0);
    chk("rst_outst", outst_cnt, 3'd0);
    resetn = 1'b1;
    step();

    // direct mode word store, request held while addr_ok low
    in_valid = 1; in_is_store = 1; in_size = 2; in_vaddr = 32'h1C000104; in_wdata = 32'hA5;
    #1 chk("da_ready", in_ready, 1'b1);
    step(); in_valid = 0;
    chk("da_req", bus.data_sram_req, 1'b1);
    chk("da_wr", bus.data_sram_wr, 1'b1);
    chk("da_addr", bus.data_sram_addr, 32'h1C000104);
    chk("da_wstrb", bus.data_sram_wstrb, 4'hF);
    chk("da_wdata", bus.data_sram_wdata, 32'h000000A5);
    chk("da_size", bus.data_sram_size, 2'd2);
    repeat (3) begin
      step();
      chk("da_hold_req", bus.data_sram_req, 1'b1);
      chk("da_hold_addr", bus.data_sram_addr, 32'h1C000104);
      chk("da_hold_ready", in_ready, 1'b0);
    end
    bus.data_sram_addr_ok = 1; #1 chk("da_outst_pre", outst_cnt, 3'd0);
    step(); bus.data_sram_addr_ok = 0;
    chk("da_req_drop", bus.data_sram_req, 1'b0);
    chk("da_outst_1", outst_cnt, 3'd1);
    bus.data_sram_data_ok = 1;
    #1 chk("da_resp_valid", resp_valid, 1'b1);
    chk("da_resp_disc", resp_discard, 1'b0);
    step(); bus.data_sram_data_ok = 0;
    chk("da_outst_0", outst_cnt, 3'd0);

    // DMW translation
    crmd_da = 0; crmd_pg = 1; cur_plv = 0; dmw_cfg = 16'h00A1;
    issue(0, 2'd0, 32'hA0001003, 32'h0);
    chk("dmw_addr", bus.data_sram_addr, 32'h00001003);
    chk("dmw_wstrb", bus.data_sram_wstrb, 4'h0);
    chk("dmw_size", bus.data_sram_size, 2'd0);
    chk("dmw_wr", bus.data_sram_wr, 1'b0);
    complete();
    issue(1, 2'd0, 32'hA0001003, 32'h123456C3);
    chk("byte_wstrb", bus.data_sram_wstrb, 4'h8);
    chk("byte_wdata", bus.data_sram_wdata, 32'hC3C3C3C3);
    complete();
    issue(1, 2'd1, 32'hA0001002, 32'h0000BEEF);
    chk("half_wstrb", bus.data_sram_wstrb, 4'hC);
    chk("half_wdata", bus.data_sram_wdata, 32'hBEEFBEEF);
    complete();
    dmw_cfg = 16'hBDA1;
    issue(0, 2'd0, 32'hA0001003, 32'h0);
    chk("dmw_prio", bus.data_sram_addr, 32'h00001003);
    complete();
    dmw_cfg = 16'hBD00;
    issue(0, 2'd0, 32'hA0001003, 32'h0);
    chk("dmw1_addr", bus.data_sram_addr, 32'hE0001003);
    complete();

    // TLB translation
    dmw_cfg = 16'h00A1; tlb_found = 1; tlb_v = 1; tlb_d = 1; tlb_plv = 3;
    tlb_ppn = 20'h12345; tlb_ps = 6'd21; in_vaddr = 32'h00654321;
    #1 chk("tlb_vppn", tlb_vppn, 19'h0032A);
    chk("tlb_bit12", tlb_va_bit12, 1'b0);
    issue(0, 2'd0, 32'h00654321, 32'h0);
    chk("tlb_4m_addr", bus.data_sram_addr, 32'h12254321);
    complete();
    tlb_ps = 6'd12;
    issue(0, 2'd0, 32'h00654321, 32'h0);
    chk("tlb_4k_addr", bus.data_sram_addr, 32'h12345321);
    complete();

    // exceptions in priority order
    tlb_found = 0;
    excp_case("ale", 1'b1, 32'h00654301, 6'b100000);
    excp_case("tlbr", 1'b0, 32'h00654300, 6'b010000);
    tlb_found = 1; tlb_v = 0;
    excp_case("pil", 1'b0, 32'h00654300, 6'b001000);
    excp_case("pis", 1'b1, 32'h00654300, 6'b000100);
    tlb_v = 1; cur_plv = 3; tlb_plv = 0;
    excp_case("ppi", 1'b0, 32'h00654300, 6'b000010);
    cur_plv = 0; tlb_plv = 3; tlb_d = 0;
    excp_case("pme", 1'b1, 32'h00654300, 6'b000001);
    tlb_d = 1;

    // outstanding limit
    crmd_da = 1; crmd_pg = 0;
    repeat (4) begin
      issue(0, 2'd2, 32'h100, 32'h0);
      bus.data_sram_addr_ok = 1; step(); bus.data_sram_addr_ok = 0;
    end
    chk("full_outst", outst_cnt, 3'd4);
    in_valid = 1; in_is_store = 0; in_size = 2; in_vaddr = 32'h200;
    #1 chk("full_ready", in_ready, 1'b0);
    bus.data_sram_data_ok = 1;
    #1 chk("full_ready_dok", in_ready, 1'b1);
    chk("full_resp", resp_valid, 1'b1);
    step(); in_valid = 0; bus.data_sram_data_ok = 0;
    chk("full_outst_3", outst_cnt, 3'd3);
    chk("full_req", bus.data_sram_req, 1'b1);
    bus.data_sram_addr_ok = 1; step(); bus.data_sram_addr_ok = 0;
    chk("full_outst_4", outst_cnt, 3'd4);
    bus.data_sram_data_ok = 1; step(); step(); bus.data_sram_data_ok = 0;
    chk("drain_2", outst_cnt, 3'd2);

    // flush with two outstanding and one in REQ
    issue(0, 2'd2, 32'h300, 32'h0);
    flush = 1;
    #1 chk("flush_ready", in_ready, 1'b0);
    step(); flush = 0;
    chk("flush_req_held", bus.data_sram_req, 1'b1);
    chk("flush_addr_held", bus.data_sram_addr, 32'h300);
    bus.data_sram_addr_ok = 1; step(); bus.data_sram_addr_ok = 0;
    chk("flush_outst", outst_cnt, 3'd3);
    issue(0, 2'd2, 32'h400, 32'h0);
    bus.data_sram_addr_ok = 1; step(); bus.data_sram_addr_ok = 0;
    chk("live_outst", outst_cnt, 3'd4);
    bus.data_sram_data_ok = 1;
    repeat (3) begin
      #1 chk("cancel_disc", resp_discard, 1'b1);
      chk("cancel_valid", resp_valid, 1'b0);
      step();
    end
    #1 chk("live_valid", resp_valid, 1'b1);
    chk("live_disc", resp_discard, 1'b0);
    step(); bus.data_sram_data_ok = 0;
    chk("end_outst", outst_cnt, 3'd0);

    // asynchronous reset mid-request
    issue(1, 2'd2, 32'h500, 32'hDEADBEEF);
    chk("mid_req", bus.data_sram_req, 1'b1);
    resetn = 0;
    #1 chk("async_req", bus.data_sram_req, 1'b0);
    chk("async_addr", bus.data_sram_addr, 32'h0);
    chk("async_wstrb", bus.data_sram_wstrb, 4'h0);
    step(); resetn = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
